// File: rtl/axil_mem_pkg.sv
// Shared types and constants for the AXI4-Lite memory responder.
package axil_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_COLLECT,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rd_state_t;

    function automatic int byte_lanes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/axil_mem_ram.sv
// Simple dual-port RAM: byte-enabled write port, registered read port.
// A read and write to the same word on one edge returns the old contents.
module axil_mem_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                clock,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                re,
    input  logic [AW-1:0]       raddr,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/axil_mem_responder.sv
// AXI4-Lite slave backed by a word memory, with configurable read latency.
// One outstanding transaction per direction; all outputs are registered.
module axil_mem_responder
    import axil_mem_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready
);

    localparam int LANES  = byte_lanes(DATA_W);
    localparam int LSB    = $clog2(LANES);
    localparam int IDX_W  = ADDR_W - LSB;
    localparam int RAM_AW = $clog2(DEPTH);
    localparam int CNT_W  = 4;
    localparam logic [IDX_W:0]   DEPTH_C  = (IDX_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return {1'b0, idx} < DEPTH_C;
    endfunction

    // Sub-word address bits carry no information for a word memory.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{awaddr[LSB-1:0], araddr[LSB-1:0]};

    wr_state_t           wr_state, wr_next;
    logic                aw_held, w_held;
    logic [IDX_W-1:0]    aw_idx_q;
    logic [DATA_W-1:0]   w_data_q;
    logic [LANES-1:0]    w_strb_q;
    logic                aw_fire, w_fire, wr_commit, b_done;

    rd_state_t           rd_state, rd_next;
    logic [CNT_W-1:0]    rd_cnt;
    logic                ar_err_q;
    logic                ar_fire, r_load, r_done;
    logic [DATA_W-1:0]   ram_rdata;

    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;
    assign ar_fire = arvalid && arready;

    always_comb begin
        wr_next   = wr_state;
        wr_commit = 1'b0;
        b_done    = 1'b0;
        case (wr_state)
            W_COLLECT: begin
                if (aw_held && w_held) begin
                    wr_commit = 1'b1;
                    wr_next   = W_RESP;
                end
            end
            W_RESP: begin
                if (bvalid && bready) begin
                    b_done  = 1'b1;
                    wr_next = W_COLLECT;
                end
            end
            default: wr_next = W_COLLECT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_state <= W_COLLECT;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
        end else begin
            wr_state <= wr_next;
            // Ready drops on its own handshake and reopens one cycle after the B handshake.
            awready  <= (wr_state == W_COLLECT) && !aw_held && !aw_fire;
            wready   <= (wr_state == W_COLLECT) && !w_held && !w_fire;
            if (aw_fire) begin
                aw_held  <= 1'b1;
                aw_idx_q <= awaddr[ADDR_W-1:LSB];
            end
            if (w_fire) begin
                w_held   <= 1'b1;
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
            if (wr_commit) begin
                bvalid <= 1'b1;
                bresp  <= in_range(aw_idx_q) ? RESP_OKAY : RESP_SLVERR;
            end
            if (b_done) begin
                bvalid  <= 1'b0;
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_next = rd_state;
        r_load  = 1'b0;
        r_done  = 1'b0;
        case (rd_state)
            R_IDLE: if (ar_fire) rd_next = R_WAIT;
            R_WAIT: begin
                if (rd_cnt == '0) begin
                    r_load  = 1'b1;
                    rd_next = R_RESP;
                end
            end
            R_RESP: begin
                if (rvalid && rready) begin
                    r_done  = 1'b1;
                    rd_next = R_IDLE;
                end
            end
            default: rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_state <= R_IDLE;
            rd_cnt   <= '0;
            ar_err_q <= 1'b0;
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rresp    <= RESP_OKAY;
            rdata    <= '0;
        end else begin
            rd_state <= rd_next;
            arready  <= (rd_state == R_IDLE) && !ar_fire;
            if (ar_fire) begin
                rd_cnt   <= CNT_LOAD;
                ar_err_q <= !in_range(araddr[ADDR_W-1:LSB]);
            end else if (rd_state == R_WAIT && rd_cnt != '0) begin
                rd_cnt <= rd_cnt - 1'b1;
            end
            if (r_load) begin
                rvalid <= 1'b1;
                rresp  <= ar_err_q ? RESP_SLVERR : RESP_OKAY;
                rdata  <= ar_err_q ? '0 : ram_rdata;
            end
            if (r_done) rvalid <= 1'b0;
        end
    end

    axil_mem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_ram (
        .clock  (clock),
        .we     (wr_commit && in_range(aw_idx_q)),
        .waddr  (aw_idx_q[RAM_AW-1:0]),
        .wdata  (w_data_q),
        .wstrb  (w_strb_q),
        .re     (ar_fire),
        .raddr  (araddr[LSB +: RAM_AW]),
        .rdata  (ram_rdata)
    );

endmodule

// File: tb/tb_axil_mem_responder.sv
// Directed bench for axil_mem_responder with hand-computed expectations.
module tb_axil_mem_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [11:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    axil_mem_responder #(
        .ADDR_W (12),
        .DATA_W (32),
        .DEPTH  (256),
        .RD_LAT (2)
    ) u_dut (
        .clock   (clock),
        .reset   (reset),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic do_write(input string tag, input logic [11:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] exp_r);
        awvalid = 1'b1; awaddr = a;
        wvalid  = 1'b1; wdata  = d; wstrb = s;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk({tag, ":bvalid_early"}, bvalid, 0);
        tick();
        chk({tag, ":bvalid"}, bvalid, 1);
        chk({tag, ":bresp"}, bresp, exp_r);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk({tag, ":bvalid_drop"}, bvalid, 0);
        chk({tag, ":awready_gap"}, awready, 0);
        tick();
        chk({tag, ":awready_back"}, awready, 1);
        chk({tag, ":wready_back"}, wready, 1);
    endtask

    task automatic do_read(input string tag, input logic [11:0] a, input logic [31:0] exp_d,
                           input logic [1:0] exp_r);
        arvalid = 1'b1; araddr = a;
        tick();
        arvalid = 1'b0;
        chk({tag, ":arready_drop"}, arready, 0);
        chk({tag, ":rvalid_n0"}, rvalid, 0);
        tick();
        chk({tag, ":rvalid_n1"}, rvalid, 0);
        tick();
        chk({tag, ":rvalid_n2"}, rvalid, 1);
        chk({tag, ":rdata"}, rdata, exp_d);
        chk({tag, ":rresp"}, rresp, exp_r);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk({tag, ":rvalid_drop"}, rvalid, 0);
        chk({tag, ":arready_gap"}, arready, 0);
        tick();
        chk({tag, ":arready_back"}, arready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;

        // Reset values
        tick(); tick(); tick();
        chk("rst:awready", awready, 0);
        chk("rst:wready", wready, 0);
        chk("rst:arready", arready, 0);
        chk("rst:bvalid", bvalid, 0);
        chk("rst:rvalid", rvalid, 0);
        chk("rst:bresp", bresp, 0);
        chk("rst:rresp", rresp, 0);
        chk("rst:rdata", rdata, 0);
        reset = 1'b0;
        tick();
        chk("rel:awready", awready, 1);
        chk("rel:wready", wready, 1);
        chk("rel:arready", arready, 1);

        // W before AW
        wvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        tick();
        wvalid = 1'b0;
        chk("wfirst:wready_drop", wready, 0);
        chk("wfirst:awready_open", awready, 1);
        chk("wfirst:bvalid_idle", bvalid, 0);
        tick(); tick();
        awvalid = 1'b1; awaddr = 12'h010;
        tick();
        awvalid = 1'b0;
        chk("wfirst:awready_drop", awready, 0);
        chk("wfirst:bvalid_early", bvalid, 0);
        tick();
        chk("wfirst:bvalid", bvalid, 1);
        chk("wfirst:bresp", bresp, 0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("wfirst:bvalid_drop", bvalid, 0);
        chk("wfirst:awready_gap", awready, 0);
        tick();
        chk("wfirst:awready_back", awready, 1);
        chk("wfirst:wready_back", wready, 1);
        do_read("wfirst_rd", 12'h010, 32'hDEADBEEF, 2'b00);

        // Partial strobe
        do_write("strb_a", 12'h040, 32'h11223344, 4'hF, 2'b00);
        do_write("strb_b", 12'h040, 32'hAABBCCDD, 4'h5, 2'b00);
        do_read("strb_rd", 12'h040, 32'h11BB33DD, 2'b00);

        // Out of range (index 256 would alias word 0 if unguarded) and empty strobe
        do_write("w0", 12'h000, 32'hCAFE0001, 4'hF, 2'b00);
        do_write("oor_wr", 12'h400, 32'h55555555, 4'hF, 2'b10);
        do_read("oor_rd", 12'h400, 32'h0, 2'b10);
        do_read("w0_rd", 12'h000, 32'hCAFE0001, 2'b00);
        do_write("strb0", 12'h000, 32'hFFFFFFFF, 4'h0, 2'b00);
        do_read("strb0_rd", 12'h000, 32'hCAFE0001, 2'b00);

        // Backpressure on B and R simultaneously
        do_write("bp_pre", 12'h080, 32'h0BADF00D, 4'hF, 2'b00);
        awvalid = 1'b1; awaddr = 12'h084; wvalid = 1'b1; wdata = 32'h00000077; wstrb = 4'hF;
        arvalid = 1'b1; araddr = 12'h080;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp:bvalid", bvalid, 1);
            chk("bp:bresp", bresp, 0);
            chk("bp:rvalid", rvalid, 1);
            chk("bp:rdata", rdata, 32'h0BADF00D);
            chk("bp:rresp", rresp, 0);
            chk("bp:awready", awready, 0);
            chk("bp:wready", wready, 0);
            chk("bp:arready", arready, 0);
            tick();
        end
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        chk("bp:bvalid_drop", bvalid, 0);
        chk("bp:rvalid_drop", rvalid, 0);
        tick();
        chk("bp:awready_back", awready, 1);
        chk("bp:arready_back", arready, 1);
        do_read("bp_rd", 12'h084, 32'h00000077, 2'b00);

        // Same-edge collision: AR handshake on the write-commit edge sees old data
        do_write("col_pre", 12'h020, 32'h00000001, 4'hF, 2'b00);
        awvalid = 1'b1; awaddr = 12'h020; wvalid = 1'b1; wdata = 32'h00000002; wstrb = 4'hF;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        arvalid = 1'b1; araddr = 12'h020;
        chk("col:bvalid_early", bvalid, 0);
        tick();
        arvalid = 1'b0;
        chk("col:bvalid", bvalid, 1);
        chk("col:arready_drop", arready, 0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("col:bvalid_drop", bvalid, 0);
        chk("col:rvalid_early", rvalid, 0);
        tick();
        chk("col:rvalid", rvalid, 1);
        chk("col:rdata_old", rdata, 32'h00000001);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk("col:rvalid_drop", rvalid, 0);
        tick();
        chk("col:arready_back", arready, 1);
        chk("col:awready_back", awready, 1);
        do_read("col_rd", 12'h020, 32'h00000002, 2'b00);

        // Reset while the read is waiting on latency
        arvalid = 1'b1; araddr = 12'h010;
        tick();
        arvalid = 1'b0;
        reset = 1'b1;
        tick();
        chk("rrst:rvalid", rvalid, 0);
        chk("rrst:arready", arready, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("rrst:arready_back", arready, 1);
        chk("rrst:awready_back", awready, 1);
        for (int i = 0; i < 3; i++) begin
            chk("rrst:no_rvalid", rvalid, 0);
            tick();
        end
        do_read("rrst_rd", 12'h010, 32'hDEADBEEF, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
